// File: rtl/reservation_station.sv
// Reservation station: holds up to ENTRIES issued operations, tracks operand
// readiness through result broadcasts, and hands the lowest-index ready line
// to the functional unit. A line stays allocated until its own result is
// broadcast, so nothing in flight is lost.
module reservation_station #(
   parameter int ENTRIES = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic [3:0]  issue_op,
   input  logic [3:0]  issue_rd,
   input  logic [15:0] issue_vj,
   input  logic [2:0]  issue_qj,
   input  logic        issue_wj,
   input  logic [15:0] issue_vk,
   input  logic [2:0]  issue_qk,
   input  logic        issue_wk,
   output logic        issue_ready,
   output logic [2:0]  issue_tag,
   input  logic        cdb_done,
   input  logic [22:0] cdb_solution,
   input  logic        fu_request,
   output logic        run,
   output logic [42:0] instruction,
   output logic [3:0]  count,
   output logic        full
);

   typedef enum logic [1:0] {
      ST_FREE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2,
      ST_EXEC  = 2'd3
   } line_state_t;

   // Idle pattern: opcode 1111 so an idle slot can never be mistaken for ADD.
   localparam logic [42:0] NOP_INSTR = {3'b000, 4'b1111, 4'b0000, 32'h0000_0000};

   line_state_t state_r [ENTRIES];
   line_state_t state_s [ENTRIES];
   logic [3:0]  op_r    [ENTRIES];
   logic [3:0]  op_s    [ENTRIES];
   logic [3:0]  rd_r    [ENTRIES];
   logic [3:0]  rd_s    [ENTRIES];
   logic [15:0] vj_r    [ENTRIES];
   logic [15:0] vj_s    [ENTRIES];
   logic [15:0] vk_r    [ENTRIES];
   logic [15:0] vk_s    [ENTRIES];
   logic [2:0]  qj_r    [ENTRIES];
   logic [2:0]  qj_s    [ENTRIES];
   logic [2:0]  qk_r    [ENTRIES];
   logic [2:0]  qk_s    [ENTRIES];
   logic        wj_r    [ENTRIES];
   logic        wj_s    [ENTRIES];
   logic        wk_r    [ENTRIES];
   logic        wk_s    [ENTRIES];

   logic [3:0]  count_r;
   logic        run_r;
   logic [42:0] instruction_r;

   logic        alloc_found_s;
   logic [2:0]  alloc_tag_s;
   logic        disp_found_s;
   logic [2:0]  disp_tag_s;
   logic [42:0] disp_word_s;
   logic        retire_s;
   logic        full_s;
   logic        issue_accept_s;
   logic        dispatch_s;
   logic        issue_wait_j_s;
   logic        issue_wait_k_s;
   logic [2:0]  cdb_tag_s;
   logic [15:0] cdb_value_s;

   assign cdb_tag_s      = cdb_solution[18:16];
   assign cdb_value_s    = cdb_solution[15:0];
   assign full_s         = (count_r == 4'(ENTRIES));
   assign issue_accept_s = issue_valid && !full_s && alloc_found_s && (issue_op <= 4'd3);
   assign dispatch_s     = fu_request && disp_found_s;
   // A pending operand whose producer is broadcasting right now is taken as valid.
   assign issue_wait_j_s = issue_wj && !(cdb_done && (cdb_tag_s == issue_qj));
   assign issue_wait_k_s = issue_wk && !(cdb_done && (cdb_tag_s == issue_qk));

   assign issue_ready = !full_s;
   assign issue_tag   = alloc_tag_s;
   assign count       = count_r;
   assign full        = full_s;
   assign run         = run_r;
   assign instruction = instruction_r;

   // Priority scans over cycle-start state: lowest free line, lowest ready line, retire hit.
   always_comb begin
      alloc_found_s = 1'b0;
      alloc_tag_s   = 3'd0;
      disp_found_s  = 1'b0;
      disp_tag_s    = 3'd0;
      disp_word_s   = NOP_INSTR;
      retire_s      = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (state_r[i] == ST_FREE) begin
            alloc_found_s = 1'b1;
            alloc_tag_s   = 3'(i);
         end else begin
            alloc_found_s = alloc_found_s;
         end
         if (state_r[i] == ST_READY) begin
            disp_found_s = 1'b1;
            disp_tag_s   = 3'(i);
            disp_word_s  = {3'(i), op_r[i], rd_r[i], vj_r[i], vk_r[i]};
         end else begin
            disp_found_s = disp_found_s;
         end
         if (cdb_done && (state_r[i] == ST_EXEC) && (cdb_tag_s == 3'(i))) begin
            retire_s = 1'b1;
         end else begin
            retire_s = retire_s;
         end
      end
   end

   // Per-line next state: allocate, wake up on broadcast, dispatch, retire.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         state_s[i] = state_r[i];
         op_s[i]    = op_r[i];
         rd_s[i]    = rd_r[i];
         vj_s[i]    = vj_r[i];
         vk_s[i]    = vk_r[i];
         qj_s[i]    = qj_r[i];
         qk_s[i]    = qk_r[i];
         wj_s[i]    = wj_r[i];
         wk_s[i]    = wk_r[i];
         case (state_r[i])
            ST_FREE: begin
               if (issue_accept_s && (alloc_tag_s == 3'(i))) begin
                  op_s[i]    = issue_op;
                  rd_s[i]    = issue_rd;
                  qj_s[i]    = issue_qj;
                  qk_s[i]    = issue_qk;
                  wj_s[i]    = issue_wait_j_s;
                  wk_s[i]    = issue_wait_k_s;
                  vj_s[i]    = issue_wj ? cdb_value_s : issue_vj;
                  vk_s[i]    = issue_wk ? cdb_value_s : issue_vk;
                  state_s[i] = (issue_wait_j_s || issue_wait_k_s) ? ST_WAIT : ST_READY;
               end else begin
                  state_s[i] = ST_FREE;
               end
            end
            ST_WAIT: begin
               if (cdb_done && wj_r[i] && (qj_r[i] == cdb_tag_s)) begin
                  vj_s[i] = cdb_value_s;
                  wj_s[i] = 1'b0;
               end else begin
                  wj_s[i] = wj_r[i];
               end
               if (cdb_done && wk_r[i] && (qk_r[i] == cdb_tag_s)) begin
                  vk_s[i] = cdb_value_s;
                  wk_s[i] = 1'b0;
               end else begin
                  wk_s[i] = wk_r[i];
               end
               if (!wj_s[i] && !wk_s[i]) begin
                  state_s[i] = ST_READY;
               end else begin
                  state_s[i] = ST_WAIT;
               end
            end
            ST_READY: begin
               if (dispatch_s && (disp_tag_s == 3'(i))) begin
                  state_s[i] = ST_EXEC;
               end else begin
                  state_s[i] = ST_READY;
               end
            end
            ST_EXEC: begin
               if (cdb_done && (cdb_tag_s == 3'(i))) begin
                  state_s[i] = ST_FREE;
               end else begin
                  state_s[i] = ST_EXEC;
               end
            end
            default: begin
               state_s[i] = ST_FREE;
            end
         endcase
      end
   end

   // Line storage registers; reset discards every pending and in-flight line.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            state_r[i] <= ST_FREE;
            op_r[i]    <= 4'd0;
            rd_r[i]    <= 4'd0;
            vj_r[i]    <= 16'd0;
            vk_r[i]    <= 16'd0;
            qj_r[i]    <= 3'd0;
            qk_r[i]    <= 3'd0;
            wj_r[i]    <= 1'b0;
            wk_r[i]    <= 1'b0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            state_r[i] <= state_s[i];
            op_r[i]    <= op_s[i];
            rd_r[i]    <= rd_s[i];
            vj_r[i]    <= vj_s[i];
            vk_r[i]    <= vk_s[i];
            qj_r[i]    <= qj_s[i];
            qk_r[i]    <= qk_s[i];
            wj_r[i]    <= wj_s[i];
            wk_r[i]    <= wk_s[i];
         end
      end
   end

   // Occupancy counter: accepted issue adds one, retiring broadcast removes one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= 4'd0;
      end else begin
         count_r <= count_r + 4'(issue_accept_s) - 4'(retire_s);
      end
   end

   // Functional-unit side: run held high out of reset, instruction or NOP each cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run_r         <= 1'b0;
         instruction_r <= NOP_INSTR;
      end else begin
         run_r <= 1'b1;
         if (dispatch_s) begin
            instruction_r <= disp_word_s;
         end else begin
            instruction_r <= NOP_INSTR;
         end
      end
   end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of station lines; line index = 3-bit tag.
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have ports issue_valid input 1, issue_op input 4, issue_rd input 4: new operation, opcode (0 ADD, 1 SUB, 2 MUL, 3 DIV), destination register.
REQ-005 SHALL have ports issue_vj input 16, issue_qj input 3, issue_wj input 1: operand A value, or producer tag when issue_wj=1 (waiting).
REQ-006 SHALL have ports issue_vk input 16, issue_qk input 3, issue_wk input 1: same for operand B.
REQ-007 SHALL have ports issue_ready output 1 (free line exists) and issue_tag output 3 (line the next accepted issue takes).
REQ-008 SHALL have ports cdb_done input 1 and cdb_solution input 23: result broadcast {rd[22:19], tag[18:16], value[15:0]} from the functional unit.
REQ-009 SHALL have ports fu_request input 1 (functional unit accepts work), run output 1, instruction output 43 = {tag[42:40], op[39:36], rd[35:32], A[31:16], B[15:0]}.
REQ-010 SHALL have ports count output 4 (occupied lines, 0-8) and full output 1 (count==8).

Function
REQ-011 Each line SHALL be in one of FREE, WAIT (an operand pending), READY (both operands valid), EXEC (dispatched, result not yet broadcast).
REQ-012 issue_tag SHALL be the lowest-index FREE line at cycle start; issue_ready = not full, combinational from registered state.
REQ-013 Issue accepted when issue_valid & issue_ready & issue_op<=3; line captures op, rd, operands; goes READY if no operand waits, else WAIT.
REQ-014 issue_valid with issue_op>3 or with full=1 SHALL be ignored: no state change.
REQ-015 Issue bypass: if cdb_done=1 and cdb_solution[18:16] equals a waiting qj/qk in the issue cycle, that operand SHALL be captured from cdb_solution[15:0] as valid.
REQ-016 Wakeup: every WAIT line whose pending tag equals cdb_solution[18:16] while cdb_done=1 SHALL capture value[15:0]; both operands matching SHALL both capture; line goes READY on the next edge once both valid.
REQ-017 Dispatch: when fu_request=1, lowest-index line READY at cycle start SHALL be sent: instruction registered with its fields, line to EXEC.
REQ-018 Idle cycles (no READY line or fu_request=0) SHALL register instruction = {3'b000, 4'b1111, 4'b0000, 32'h0} (NOP opcode, never an ADD).
REQ-019 run SHALL be 1 every cycle after reset release; run never drops between dispatch and broadcast, so in-flight results are not lost.
REQ-020 Retire: EXEC line matching cdb_solution[18:16] with cdb_done=1 SHALL become FREE on that edge; broadcast for a non-EXEC line SHALL not free it.
REQ-021 A line freed this cycle SHALL NOT be allocated this cycle (allocation uses cycle-start state).
REQ-022 A line woken this cycle SHALL NOT dispatch this cycle; earliest dispatch is the cycle after it shows READY.
REQ-023 Simultaneous issue, wakeup, dispatch and retire in one cycle SHALL all take effect; count = old + accepted issue - retire.
REQ-024 Dispatch-to-broadcast latency SHALL be that of the functional unit (2 edges); station imposes no extra delay.

Reset
REQ-025 On reset=1: all lines FREE, count=0, full=0, issue_ready=1, issue_tag=0, run=0, instruction=NOP pattern of REQ-018.
REQ-026 Reset asserted mid-operation SHALL discard all pending and EXEC lines; broadcasts arriving after release for discarded tags SHALL be ignored.

Verification
REQ-027 Issue ADD rd=3, A=5, B=7, no waits, fu_request=1 -> next edge instruction={0,0000,0011,0005h,0007h}, run=1; cdb tag 0 -> count returns 0.
REQ-028 Issue 8 ops without broadcasts -> tags 0..7 in order, full=1, issue_ready=0; 9th issue ignored, count stays 8.
REQ-029 Issue SUB tag1 with wj=1,qj=0 while tag0 in EXEC; cdb_done with {rd,0,0010h} -> tag1 captures A=0010h, dispatches following cycle.
REQ-030 Issue with wj=1,qj=2 in same cycle cdb broadcasts tag2 value 00FFh -> operand captured at issue, line READY immediately.
REQ-031 Two READY lines (tags 1, 4), fu_request=1 -> tag1 dispatched first, tag4 next cycle; fu_request=0 -> NOP opcode 1111 sent, run stays 1.
REQ-032 Assert reset with 3 lines occupied, 1 in EXEC -> count=0, run=0 at once; after release broadcast of old tag causes no change.
